r3_input_gather: RTL and testbench
==================================

R3_INPUT_GATHER -- requirements
Module: r3_input_gather

Interface
REQ-001 Parameter SIGN_BIT, default 1: sign bits per fixed-point word.
REQ-002 Parameter INT_BIT, default 6: integer bits per word.
REQ-003 Parameter FLT_BIT, default 6: fractional bits per word; DW = SIGN_BIT+INT_BIT+FLT_BIT.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  upstream sample valid.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 in_sof  input  1  sample is first of a frame (slot 0 of a radix-3 group).
REQ-009 in_re, in_im  input  DW each  complex sample, two's complement.
REQ-010 out_valid  output  1  a complete group is held on the outputs.
REQ-011 out_ready  input  1  downstream 3-input adder stage consumes the group.
REQ-012 out_a_re, out_a_im, out_b_re, out_b_im, out_c_re, out_c_im  output  DW each  group samples x0, x1, x2 in arrival order.
REQ-013 out_err  output  1  one-cycle pulse: misaligned in_sof dropped a partial group.
REQ-014 grp_cnt  output  8  count of groups delivered, wraps 255->0.

Function
REQ-015 A transfer in occurs when in_valid && in_ready; a transfer out occurs when out_valid && out_ready.
REQ-016 A slot counter (states S0, S1, S2) selects the collect register written on each input transfer: S0->a, S1->b, S2->c; it advances S0->S1->S2->S0 per input transfer.
REQ-017 Samples are stored bit-exact; no rounding, extension or saturation (the adder stage does width growth).
REQ-018 On an input transfer in S2, the completed group (a, b, new c) is loaded into the output register on the same edge; out_valid rises the next cycle (latency one cycle after the third sample).
REQ-019 in_ready = 1 in S0 and S1; in S2, in_ready = !out_valid || out_ready (a group completes in the same cycle the previous one leaves, for sustained one-sample-per-cycle throughput).
REQ-020 Output data is stable while out_valid && !out_ready; out_valid drops after a transfer out unless a new group loads on the same edge.
REQ-021 Transfer out with no new group: out_valid = 0 next cycle, output data holds last values.
REQ-022 grp_cnt increments on each transfer out, modulo 256.
REQ-023 in_sof accepted in S0: normal, slot-0 write.
REQ-024 in_sof accepted in S1 or S2: partial group discarded, the sample written as slot a, counter set to S1, out_err = 1 for exactly the next cycle; the output register is unaffected.
REQ-025 in_sof in S2 with in_ready = 0: no transfer, no effect.
REQ-026 in_sof is ignored when in_valid = 0.
REQ-027 out_err is 0 in all cycles not covered by REQ-024.

Reset
REQ-028 When rst_n = 0 at a rising edge: slot counter = S0, out_valid = 0, out_err = 0, grp_cnt = 0, all data registers = 0; in_ready = 1 the cycle after reset.
REQ-029 Reset mid-group or with out_valid = 1 discards all held samples and any undelivered group; no transfer out occurs during a reset cycle.

Verification
REQ-030 Basic: out_ready = 1, feed re = 1,2,3 (im = -1,-2,-3) on consecutive cycles with in_sof on first -> one cycle after the third, out_valid = 1, a/b/c_re = 1/2/3, a/b/c_im = -1/-2/-3, grp_cnt = 1 after transfer.
REQ-031 Streaming: 300 samples back-to-back, out_ready = 1 -> in_ready never drops, 100 groups in order, grp_cnt = 100 (wrap checked with 800 samples -> grp_cnt = 10).
REQ-032 Backpressure: out_ready = 0 after first group; feed 6 samples -> 5 accepted, in_ready = 0 in S2, out data unchanged; raise out_ready -> group 2 loads same cycle, no loss or duplication.
REQ-033 Misaligned sof: samples 10, 11, then 20 with in_sof, then 21, 22 -> out_err pulses one cycle after 20, next group = 20/21/22, 10/11 never appear.
REQ-034 Reset mid-operation: assert rst_n = 0 after 2 samples of a group with one group pending -> out_valid = 0, grp_cnt = 0; next three samples form a fresh group.
REQ-035 Full-scale values: samples -2^(DW-1) and 2^(DW-1)-1 pass unchanged on all six outputs.

Source files
------------

// File: rtl/r3_input_gather.sv
// Radix-3 input gather: collects three complex samples into a group and hands
// the group to the 3-input adder stage through a valid/ready output register.
module r3_input_gather #(
  parameter int SIGN_BIT = 1,
  parameter int INT_BIT  = 6,
  parameter int FLT_BIT  = 6,
  localparam int DW = SIGN_BIT + INT_BIT + FLT_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_a_re,
  output logic signed [DW-1:0] out_a_im,
  output logic signed [DW-1:0] out_b_re,
  output logic signed [DW-1:0] out_b_im,
  output logic signed [DW-1:0] out_c_re,
  output logic signed [DW-1:0] out_c_im,
  output logic                 out_err,
  output logic [7:0]           grp_cnt
);

  typedef enum logic [1:0] {S0, S1, S2} slot_t;

  slot_t                slot, slot_nxt;
  logic                 xfer_in, xfer_out, sof_mis, grp_load;
  logic signed [DW-1:0] a_re_p0, a_im_p0, b_re_p0, b_im_p0;
  logic                 vld_p1, err_p1;
  logic [7:0]           cnt_p1;

  // The third sample may enter in the same cycle the held group leaves.
  assign in_ready  = (slot != S2) || !vld_p1 || out_ready;
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = vld_p1 && out_ready;
  assign sof_mis   = xfer_in && in_sof && (slot != S0);
  assign grp_load  = xfer_in && !sof_mis && (slot == S2);

  assign out_valid = vld_p1;
  assign out_err   = err_p1;
  assign grp_cnt   = cnt_p1;

  always_comb begin
    slot_nxt = slot;
    if (sof_mis) begin
      slot_nxt = S1;
    end else if (xfer_in) begin
      case (slot)
        S0:      slot_nxt = S1;
        S1:      slot_nxt = S2;
        default: slot_nxt = S0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) slot <= S0;
    else        slot <= slot_nxt;
  end

  // ---- stage p0: collect slots a and b ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_re_p0 <= '0;
      a_im_p0 <= '0;
      b_re_p0 <= '0;
      b_im_p0 <= '0;
    end else if (xfer_in && (slot == S0 || sof_mis)) begin
      a_re_p0 <= in_re;
      a_im_p0 <= in_im;
    end else if (xfer_in && slot == S1) begin
      b_re_p0 <= in_re;
      b_im_p0 <= in_im;
    end
  end

  // ---- stage p1: output group register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_a_re <= '0;
      out_a_im <= '0;
      out_b_re <= '0;
      out_b_im <= '0;
      out_c_re <= '0;
      out_c_im <= '0;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      if (grp_load) begin
        out_a_re <= a_re_p0;
        out_a_im <= a_im_p0;
        out_b_re <= b_re_p0;
        out_b_im <= b_im_p0;
        out_c_re <= in_re;
        out_c_im <= in_im;
      end
      vld_p1 <= grp_load || (vld_p1 && !out_ready);
      err_p1 <= sof_mis;
      if (xfer_out) cnt_p1 <= cnt_p1 + 8'd1;
    end
  end

endmodule

// File: tb/tb_r3_input_gather.sv
// Bench for r3_input_gather: directed vectors, a group-level reference model
// checked every cycle, and literal spot checks on key scenarios.
module tb_r3_input_gather;
  localparam int DW   = 13;
  localparam int VMIN = -(1 << (DW - 1));
  localparam int VMAX = (1 << (DW - 1)) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n, in_valid, in_sof, out_ready;
  logic                 in_ready, out_valid, out_err;
  logic signed [DW-1:0] in_re, in_im;
  logic signed [DW-1:0] out_a_re, out_a_im, out_b_re, out_b_im, out_c_re, out_c_im;
  logic [7:0]           grp_cnt;

  r3_input_gather dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_re(in_re), .in_im(in_im), .out_valid(out_valid),
    .out_ready(out_ready), .out_a_re(out_a_re), .out_a_im(out_a_im),
    .out_b_re(out_b_re), .out_b_im(out_b_im), .out_c_re(out_c_re),
    .out_c_im(out_c_im), .out_err(out_err), .grp_cnt(grp_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int stalls = 0;

  // Reference model: a partial group as a queue of {re,im}, plus the group
  // that should currently be presented downstream.
  logic [2*DW-1:0] part[$];
  logic [6*DW-1:0] e_data = '0;
  logic            e_valid = 1'b0, e_err = 1'b0, chk_en = 1'b0;
  logic [7:0]      e_cnt = '0;
  bit              m_rdy, m_xi, m_xo;

  function automatic bit model_ready();
    return (part.size() < 2) || !e_valid || out_ready;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      part.delete();
      e_valid = 1'b0;
      e_err   = 1'b0;
      e_cnt   = '0;
      e_data  = '0;
      chk_en  = 1'b1;
    end else if (chk_en) begin
      m_rdy = model_ready();
      m_xi  = in_valid && m_rdy;
      m_xo  = e_valid && out_ready;
      e_err = 1'b0;
      if (m_xo) begin
        e_cnt   = e_cnt + 8'd1;
        e_valid = 1'b0;
      end
      if (m_xi) begin
        if (in_sof && part.size() != 0) begin
          part.delete();
          part.push_back({in_re, in_im});
          e_err = 1'b1;
        end else begin
          part.push_back({in_re, in_im});
          if (part.size() == 3) begin
            e_data  = {part[0], part[1], part[2]};
            e_valid = 1'b1;
            part.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({out_valid, out_err, in_ready, grp_cnt} !== {e_valid, e_err, model_ready(), e_cnt}) begin
        n_fail++;
        $display("FAIL ctl @%0t: actual vld/err/rdy/cnt=%b/%b/%b/%0d required=%b/%b/%b/%0d",
                 $time, out_valid, out_err, in_ready, grp_cnt, e_valid, e_err, model_ready(), e_cnt);
      end
      n_cmp++;
      if ({out_a_re, out_a_im, out_b_re, out_b_im, out_c_re, out_c_im} !== e_data) begin
        n_fail++;
        $display("FAIL data @%0t: actual=%h required=%h", $time,
                 {out_a_re, out_a_im, out_b_re, out_b_im, out_c_re, out_c_im}, e_data);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n    = 1'b1;
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic push(input int re, input int im, input bit sof);
    int  w;
    bit  acc;
    in_valid = 1'b1;
    in_sof   = sof;
    in_re    = re[DW-1:0];
    in_im    = im[DW-1:0];
    w   = 0;
    acc = 1'b0;
    while (!acc && w < 50) begin
      #1;
      acc = in_ready;
      if (!acc) stalls++;
      @(posedge clk);
      #1;
      w++;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout @%0t: actual=not accepted required=accepted", $time);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    in_re = '0; in_im = '0;
    step();
    step();
    rst_n = 1'b1;
    check("reset_valid", out_valid, 0);
    check("reset_cnt", grp_cnt, 0);
    check("reset_ready", in_ready, 1);
    check("reset_data", out_a_re, 0);

    // Basic group
    push(1, -1, 1); push(2, -2, 0); push(3, -3, 0);
    check("basic_valid", out_valid, 1);
    check("basic_a_re", out_a_re, 1);
    check("basic_b_re", out_b_re, 2);
    check("basic_c_re", out_c_re, 3);
    check("basic_a_im", out_a_im, -1);
    check("basic_c_im", out_c_im, -3);
    idle(1);
    check("basic_cnt", grp_cnt, 1);
    check("basic_drop", out_valid, 0);
    check("basic_hold", out_c_re, 3);

    // Streaming 300 samples
    do_reset();
    stalls = 0;
    for (int i = 0; i < 300; i++) push(i, -i, (i % 3) == 0);
    idle(1);
    check("stream_stalls", stalls, 0);
    check("stream_cnt", grp_cnt, 100);
    check("stream_last_c", out_c_re, 299);

    // Wrap: 800 samples -> 266 groups
    do_reset();
    for (int i = 0; i < 800; i++) push(i, -i, (i % 3) == 0);
    idle(2);
    check("wrap_cnt", grp_cnt, 10);

    // Backpressure
    do_reset();
    push(100, -100, 1); push(101, -101, 0); push(102, -102, 0);
    out_ready = 1'b0;
    push(200, -200, 1); push(201, -201, 0);
    in_valid = 1'b1; in_re = 13'sd202; in_im = -13'sd202;
    repeat (3) begin
      #1;
      check("bp_ready_low", in_ready, 0);
      check("bp_hold_a", out_a_re, 100);
      check("bp_hold_c", out_c_im, -102);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_high", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_g2_valid", out_valid, 1);
    check("bp_g2_a", out_a_re, 200);
    check("bp_g2_c", out_c_re, 202);
    check("bp_cnt1", grp_cnt, 1);
    idle(1);
    check("bp_cnt2", grp_cnt, 2);
    push(203, -203, 1); push(204, -204, 0); push(205, -205, 0);
    idle(1);
    check("bp_cnt3", grp_cnt, 3);

    // Misaligned sof, plus sof without valid
    do_reset();
    push(10, -10, 1);
    in_sof = 1'b1;
    step();
    in_sof = 1'b0;
    check("sof_novalid_err", out_err, 0);
    push(11, -11, 0);
    push(20, -20, 1);
    check("mis_err", out_err, 1);
    push(21, -21, 0);
    check("mis_err_clr", out_err, 0);
    push(22, -22, 0);
    check("mis_valid", out_valid, 1);
    check("mis_a", out_a_re, 20);
    check("mis_b", out_b_re, 21);
    check("mis_c", out_c_re, 22);
    idle(1);

    // Reset mid-operation with a pending group
    do_reset();
    push(30, 0, 1); push(31, 0, 0); push(32, 0, 0);
    idle(1);
    out_ready = 1'b0;
    push(33, 0, 1); push(34, 0, 0); push(35, 0, 0);
    push(40, 0, 1); push(41, 0, 0);
    check("pre_rst_cnt", grp_cnt, 1);
    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_cnt", grp_cnt, 0);
    check("rst_data", out_b_re, 0);
    out_ready = 1'b1;
    push(50, -50, 1); push(51, -51, 0); push(52, -52, 0);
    check("fresh_a", out_a_re, 50);
    check("fresh_b", out_b_re, 51);
    check("fresh_c", out_c_re, 52);
    idle(1);

    // Full-scale values
    do_reset();
    push(VMIN, VMAX, 1); push(VMAX, VMIN, 0); push(VMIN, VMAX, 0);
    check("fs_a_re", out_a_re, VMIN);
    check("fs_a_im", out_a_im, VMAX);
    check("fs_b_re", out_b_re, VMAX);
    check("fs_b_im", out_b_im, VMIN);
    check("fs_c_re", out_c_re, VMIN);
    check("fs_c_im", out_c_im, VMAX);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
